// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU requantization output stage.
package tpu_pkg;

  localparam int LANES      = 4;
  localparam int ACC_W      = 32;
  localparam int IDX_W      = 16;
  localparam int BIAS_IDX_W = 7;
  localparam int PIPE_DEPTH = 4;

  localparam logic signed [ACC_W-1:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [ACC_W-1:0] INT32_MAX = 32'sh7FFF_FFFF;

  // Rounding nudges for the doubling high multiply: +2^30 and 1-2^30.
  localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
  localparam logic signed [63:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/tpu_requant_lane.sv
// One requant lane: bias add, SRDHM, rounding shift, offset and int8 clamp.
// TPU_REQUANT_STATS_EN adds a per-lane saturation flag for the top-level counter.
module tpu_requant_lane
  import tpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_out_i,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [ACC_W-1:0] bias_i,
  input  logic signed [ACC_W-1:0] mult_i,
  input  logic        [4:0]       shift_i,
  input  logic signed [ACC_W-1:0] offset_i,
  input  logic signed [7:0]       act_min_i,
  input  logic signed [7:0]       act_max_i,
`ifdef TPU_REQUANT_STATS_EN
  output logic                    sat_o,
`endif
  output logic        [7:0]       q_o
);

  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic signed [ACC_W-1:0] r_q, r_d;
  logic        [7:0]       out_q, out_d;

  logic signed [63:0]      prod, nudged, floor_v, trunc_v;
  logic        [ACC_W-1:0] mask, rem, thr;
  logic signed [ACC_W-1:0] shr, q_v;
  logic signed [32:0]      o_v, hi33, lo33, clip;
  logic                    o_hi, o_lo;

  always_comb begin
    sum_d   = acc_i + bias_i;
    prod    = {{32{sum_q[31]}}, sum_q} * {{32{mult_i[31]}}, mult_i};
    nudged  = prod + (prod[63] ? NUDGE_NEG : NUDGE_POS);
    floor_v = nudged >>> 31;
    // Arithmetic shift floors; bump negative non-exact values to truncate toward zero.
    trunc_v = floor_v + {63'b0, nudged[63] & (|nudged[30:0])};
    if (sum_q == INT32_MIN && mult_i == INT32_MIN) r_d = INT32_MAX;
    else                                           r_d = trunc_v[31:0];
  end

  always_comb begin
    mask = (32'd1 << shift_i) - 32'd1;
    rem  = r_q & mask;
    thr  = (mask >> 1) + {31'b0, r_q[31]};
    shr  = r_q >>> shift_i;
    q_v  = shr + {31'b0, (rem > thr)};
    o_v  = {q_v[31], q_v} + {offset_i[31], offset_i};
    hi33 = {{25{act_max_i[7]}}, act_max_i};
    lo33 = {{25{act_min_i[7]}}, act_min_i};
    o_hi = (o_v > hi33);
    o_lo = (o_v < lo33);
    clip = o_hi ? hi33 : o_v;
    if (clip < lo33) clip = lo33;
    out_d = clip[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      r_q   <= '0;
      out_q <= '0;
    end else begin
      sum_q <= sum_d;
      r_q   <= r_d;
      if (en_out_i) out_q <= out_d;
    end
  end

  assign q_o = out_q;
`ifdef TPU_REQUANT_STATS_EN
  assign sat_o = o_hi | o_lo;
`endif

endmodule

// File: rtl/tpu_requant.sv
// Requantization stage between the matmul C buffer and the int8 D buffer.
// TPU_REQUANT_STATS_EN adds the sat_count output and its counter.
//
// state | meaning
// IDLE  | waiting for in_valid; config latched on start
// READ  | issuing one C/bias read per cycle
// DRAIN | waiting for the pipeline to empty
module tpu_requant
  import tpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [12:0]           M,
  input  logic [8:0]            N,
  input  logic [31:0]           out_multiplier,
  input  logic [4:0]            out_shift,
  input  logic [31:0]           out_offset,
  input  logic [7:0]            act_min,
  input  logic [7:0]            act_max,
  output logic                  busy,
  output logic [IDX_W-1:0]      C_index,
  input  logic [127:0]          C_data_out,
  output logic [BIAS_IDX_W-1:0] Bias_index,
  input  logic [127:0]          Bias_data_out,
  output logic                  D_wr_en,
  output logic [IDX_W-1:0]      D_index,
  output logic [31:0]           D_data_in
`ifdef TPU_REQUANT_STATS_EN
  ,
  output logic [15:0]           sat_count
`endif
);

  state_e state_q, state_d;

  logic                  start;
  logic                  last_issue;
  logic [8:0]            n_m1;
  logic [12:0]           m_left_q, m_reload_q;
  logic [BIAS_IDX_W-1:0] nb_left_q;
  logic [IDX_W-1:0]      c_idx_q;
  logic [BIAS_IDX_W-1:0] b_idx_q;

  logic [31:0] mult_q, offset_q;
  logic [4:0]  shift_q;
  logic [7:0]  min_q, max_q;

  // vld_q[PIPE_DEPTH-1] = RAM data present ... vld_q[0] = write strobe.
  logic [PIPE_DEPTH-1:0] vld_q;
  logic [IDX_W-1:0]      idx_q [PIPE_DEPTH];
  logic [7:0]            lane_q [LANES];

  assign start      = in_valid && (state_q == IDLE);
  assign last_issue = (m_left_q == '0) && (nb_left_q == '0);
  assign n_m1       = N - 9'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (M == '0 || N == '0) ? DRAIN : READ;
      READ:    if (last_issue) state_d = DRAIN;
      DRAIN:   if (vld_q[PIPE_DEPTH-1:1] == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_left_q   <= '0;
      m_reload_q <= '0;
      nb_left_q  <= '0;
      c_idx_q    <= '0;
      b_idx_q    <= '0;
      mult_q     <= '0;
      offset_q   <= '0;
      shift_q    <= '0;
      min_q      <= '0;
      max_q      <= '0;
    end else if (start) begin
      m_left_q   <= M - 13'd1;
      m_reload_q <= M - 13'd1;
      nb_left_q  <= n_m1[8:2];
      c_idx_q    <= '0;
      b_idx_q    <= '0;
      mult_q     <= out_multiplier;
      offset_q   <= out_offset;
      shift_q    <= out_shift;
      min_q      <= act_min;
      max_q      <= act_max;
    end else if (state_q == READ) begin
      c_idx_q <= c_idx_q + 1'b1;
      if (m_left_q == '0) begin
        m_left_q  <= m_reload_q;
        nb_left_q <= nb_left_q - 1'b1;
        b_idx_q   <= b_idx_q + 1'b1;
      end else begin
        m_left_q <= m_left_q - 13'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) idx_q[i] <= '0;
    end else begin
      vld_q <= {(state_q == READ), vld_q[PIPE_DEPTH-1:1]};
      idx_q[PIPE_DEPTH-1] <= c_idx_q;
      for (int i = 0; i < PIPE_DEPTH-1; i++) idx_q[i] <= idx_q[i+1];
    end
  end

`ifdef TPU_REQUANT_STATS_EN
  logic [LANES-1:0] lane_sat;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tpu_requant_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_out_i  (vld_q[1]),
      .acc_i     (C_data_out[ACC_W*(LANES-g)-1 -: ACC_W]),
      .bias_i    (Bias_data_out[ACC_W*(LANES-g)-1 -: ACC_W]),
      .mult_i    (mult_q),
      .shift_i   (shift_q),
      .offset_i  (offset_q),
      .act_min_i (min_q),
      .act_max_i (max_q),
`ifdef TPU_REQUANT_STATS_EN
      .sat_o     (lane_sat[g]),
`endif
      .q_o       (lane_q[g])
    );
  end

  always_comb begin
    D_data_in = '0;
    for (int i = 0; i < LANES; i++) D_data_in[8*(LANES-1-i) +: 8] = lane_q[i];
  end

`ifdef TPU_REQUANT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [2:0]  sat_inc;
  logic [16:0] sat_sum;

  always_comb begin
    sat_inc = '0;
    for (int i = 0; i < LANES; i++) sat_inc = sat_inc + {2'b0, lane_sat[i]};
    sat_sum   = {1'b0, sat_cnt_q} + {14'b0, sat_inc};
    sat_cnt_d = sat_cnt_q;
    if (start)         sat_cnt_d = '0;
    else if (vld_q[1]) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`endif

  assign busy       = (state_q != IDLE);
  assign C_index    = c_idx_q;
  assign Bias_index = b_idx_q;
  assign D_wr_en    = vld_q[0];
  assign D_index    = idx_q[0];

endmodule

// File: tb/tb_tpu_requant.sv
// Scoreboard bench for tpu_requant; sat_count checked when TPU_REQUANT_STATS_EN is defined.
module tb_tpu_requant;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [12:0]  M;
  logic [8:0]   N;
  logic [31:0]  out_multiplier;
  logic [4:0]   out_shift;
  logic [31:0]  out_offset;
  logic [7:0]   act_min;
  logic [7:0]   act_max;
  logic         busy;
  logic [15:0]  C_index;
  logic [127:0] C_data_out;
  logic [6:0]   Bias_index;
  logic [127:0] Bias_data_out;
  logic         D_wr_en;
  logic [15:0]  D_index;
  logic [31:0]  D_data_in;
`ifdef TPU_REQUANT_STATS_EN
  logic [15:0]  sat_count;
`endif

  always #5 clk = ~clk;

  tpu_requant dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .M              (M),
    .N              (N),
    .out_multiplier (out_multiplier),
    .out_shift      (out_shift),
    .out_offset     (out_offset),
    .act_min        (act_min),
    .act_max        (act_max),
    .busy           (busy),
    .C_index        (C_index),
    .C_data_out     (C_data_out),
    .Bias_index     (Bias_index),
    .Bias_data_out  (Bias_data_out),
    .D_wr_en        (D_wr_en),
    .D_index        (D_index),
    .D_data_in      (D_data_in)
`ifdef TPU_REQUANT_STATS_EN
    ,
    .sat_count      (sat_count)
`endif
  );

  logic [127:0] cmem [64];
  logic [127:0] bmem [128];

  always @(posedge clk) begin
    C_data_out    <= cmem[C_index[5:0]];
    Bias_data_out <= bmem[Bias_index];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_lane(input int c, input int b, input int mult, input int sh,
                                          input int off, input int lo, input int hi);
    int     a, r;
    longint p, nudge, mask, rem, thr, q, o;
    a = c + b;
    if (a == 32'sh8000_0000 && mult == 32'sh8000_0000) begin
      r = 32'sh7FFF_FFFF;
    end else begin
      p     = longint'(a) * longint'(mult);
      nudge = (p >= 0) ? (longint'(1) << 30) : (longint'(1) - (longint'(1) << 30));
      r     = int'((p + nudge) / (longint'(1) << 31));
    end
    mask = (longint'(1) << sh) - 1;
    rem  = longint'(r) & mask;
    thr  = (mask >> 1) + ((r < 0) ? 1 : 0);
    q    = (longint'(r) >>> sh) + ((rem > thr) ? 1 : 0);
    o    = q + longint'(off);
    if (o > longint'(hi)) o = longint'(hi);
    if (o < longint'(lo)) o = longint'(lo);
    return o[7:0];
  endfunction

  function automatic logic [31:0] exp_word(input logic [127:0] c, input logic [127:0] b,
                                           input int mult, input int sh, input int off,
                                           input int lo, input int hi);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      w[31-8*i -: 8] = ref_lane(int'(c[127-32*i -: 32]), int'(b[127-32*i -: 32]),
                                mult, sh, off, lo, hi);
    return w;
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  int          wr_count = 0;
  logic [31:0] wr_log [64];
  logic [31:0] last_wr;

  always @(negedge clk) begin
    if (rst_n && D_wr_en) begin
      wr_count++;
      last_wr = D_data_in;
      wr_log[D_index[5:0]] = D_data_in;
      if (sb.size() == 0) begin
        check_val("wr_unexpected", {48'b0, D_index}, 64'h1_0000);
      end else begin
        mon_e = sb.pop_front();
        check_val("wr_idx", {48'b0, D_index}, 64'(mon_e.idx));
        check_val("wr_data", {32'b0, D_data_in}, {32'b0, mon_e.data});
        check_val("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic start_job(input int m, input int n, input int mult, input int sh,
                           input int off, input int lo, input int hi, output int k);
    int nb;
    exp_t x;
    @(negedge clk);
    M              = 13'(m);
    N              = 9'(n);
    out_multiplier = mult;
    out_shift      = 5'(sh);
    out_offset     = off;
    act_min        = 8'(lo);
    act_max        = 8'(hi);
    in_valid       = 1'b1;
    @(posedge clk);
    #1;
    k        = cyc;
    in_valid = 1'b0;
    nb = (n + 3) / 4;
    if (m != 0 && n != 0) begin
      for (int b = 0; b < nb; b++) begin
        for (int mm = 0; mm < m; mm++) begin
          x.idx  = b * m + mm;
          x.data = exp_word(cmem[x.idx], bmem[b], mult, sh, off, lo, hi);
          x.cyc  = k + 4 + x.idx;
          sb.push_back(x);
        end
      end
    end
  endtask

  task automatic wait_idle(output int low);
    low = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin
        low = cyc;
        return;
      end
    end
    check_val("idle_timeout", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, low, base;
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    M              = '0;
    N              = '0;
    out_multiplier = '0;
    out_shift      = '0;
    out_offset     = '0;
    act_min        = '0;
    act_max        = '0;
    for (int i = 0; i < 64; i++)  cmem[i] = '0;
    for (int i = 0; i < 128; i++) bmem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy",   {63'b0, busy},      64'd0);
    check_val("rst_wr_en",  {63'b0, D_wr_en},   64'd0);
    check_val("rst_c_idx",  {48'b0, C_index},   64'd0);
    check_val("rst_b_idx",  {57'b0, Bias_index}, 64'd0);
    check_val("rst_d_idx",  {48'b0, D_index},   64'd0);
    check_val("rst_d_data", {32'b0, D_data_in}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic scaling by one half
    cmem[0] = {32'd100, -32'sd100, 32'd0, 32'h0010_0000};
    bmem[0] = '0;
    base = wr_count;
    start_job(1, 4, 32'h4000_0000, 0, 0, -128, 127, k);
    wait_idle(low);
    check_val("t1_writes", 64'(wr_count - base), 64'd1);
    check_val("t1_data", {32'b0, last_wr}, 64'h32CE_007F);
    check_val("t1_busy_fall", 64'(low), 64'(k + 5));

    // round-half-away on the right shift
    cmem[0] = {32'd6, -32'sd6, 32'd5, -32'sd5};
    start_job(1, 4, 32'h4000_0000, 2, 0, -128, 127, k);
    wait_idle(low);
    check_val("t2_data", {32'b0, last_wr}, 64'h01FF_01FF);

    // INT32_MIN * INT32_MIN special case
    cmem[0] = {32'h8000_0000, 32'd0, 32'd0, 32'd0};
    start_job(1, 4, 32'h8000_0000, 0, 0, -128, 127, k);
    wait_idle(low);
    check_val("t3_data", {32'b0, last_wr}, 64'h7F00_0000);
`ifdef TPU_REQUANT_STATS_EN
    check_val("t3_sat", {48'b0, sat_count}, 64'd1);
`endif

    // two column blocks, per-block bias
    for (int i = 0; i < 10; i++) cmem[i] = '0;
    bmem[0] = {4{32'd10}};
    bmem[1] = {4{-32'sd10}};
    base = wr_count;
    start_job(5, 6, 32'h7FFF_FFFF, 0, -128, -128, 127, k);
    wait_idle(low);
    check_val("t4_writes", 64'(wr_count - base), 64'd10);
    check_val("t4_first", {32'b0, wr_log[0]}, 64'h8A8A_8A8A);
    check_val("t4_last", {32'b0, wr_log[9]}, 64'h8080_8080);
    check_val("t4_busy_fall", 64'(low), 64'(k + 14));
`ifdef TPU_REQUANT_STATS_EN
    check_val("t4_sat", {48'b0, sat_count}, 64'd20);
`endif

    // reset mid-job, then restart
    base = wr_count;
    start_job(5, 6, 32'h7FFF_FFFF, 0, -128, -128, 127, k);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (wr_count >= base + 3) break;
    end
    check_val("t5_pre_writes", 64'(wr_count - base), 64'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("t5_rst_wr_en", {63'b0, D_wr_en}, 64'd0);
    check_val("t5_rst_busy",  {63'b0, busy},    64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("t5_no_writes", 64'(wr_count - base), 64'd3);
    base = wr_count;
    start_job(5, 6, 32'h7FFF_FFFF, 0, -128, -128, 127, k);
    wait_idle(low);
    check_val("t5_restart_writes", 64'(wr_count - base), 64'd10);
    check_val("t5_busy_fall", 64'(low), 64'(k + 14));

    // in_valid while busy is ignored
    base = wr_count;
    start_job(5, 6, 32'h7FFF_FFFF, 0, -128, -128, 127, k);
    repeat (3) @(negedge clk);
    M        = 13'd1;
    N        = 9'd4;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(low);
    check_val("t6_writes", 64'(wr_count - base), 64'd10);
    check_val("t6_busy_fall", 64'(low), 64'(k + 14));
    repeat (5) @(negedge clk);
    check_val("t6_still_idle", {63'b0, busy}, 64'd0);

    // empty jobs: busy one cycle, no writes
    base = wr_count;
    start_job(0, 6, 32'h7FFF_FFFF, 0, 0, -128, 127, k);
    wait_idle(low);
    check_val("t6_m0_busy_fall", 64'(low), 64'(k + 1));
    start_job(3, 0, 32'h7FFF_FFFF, 0, 0, -128, 127, k);
    wait_idle(low);
    check_val("t6_n0_busy_fall", 64'(low), 64'(k + 1));
    repeat (6) @(negedge clk);
    check_val("t6_empty_writes", 64'(wr_count - base), 64'd0);
    check_val("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
